// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_pkg
// Description : Shared payload layout, NOP encoding and cycle-action decode
//               for the generic inter-stage pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_reg_pkg;

    localparam int c_WD_W      = 5;
    localparam int c_WORD_W    = 32;
    localparam int c_ALUOP_W   = 4;
    localparam int c_PAYLOAD_W = 107;

    // Field offsets (LSB positions) inside the flat payload vector.
    localparam int c_ALUOP_LSB = 0;
    localparam int c_WHILO_LSB = c_ALUOP_LSB + c_ALUOP_W;
    localparam int c_LO_LSB    = c_WHILO_LSB + 1;
    localparam int c_HI_LSB    = c_LO_LSB + c_WORD_W;
    localparam int c_WDATA_LSB = c_HI_LSB + c_WORD_W;
    localparam int c_WREG_LSB  = c_WDATA_LSB + c_WORD_W;
    localparam int c_WD_LSB    = c_WREG_LSB + 1;

    localparam logic                c_WRITE_DISABLE = 1'b0;
    localparam logic [c_WORD_W-1:0] c_ZERO_WORD     = '0;

    typedef struct packed {
        logic [c_WD_W-1:0]    wd;
        logic                 wreg;
        logic [c_WORD_W-1:0]  wdata;
        logic [c_WORD_W-1:0]  hi;
        logic [c_WORD_W-1:0]  lo;
        logic                 whilo;
        logic [c_ALUOP_W-1:0] aluop;
    } payload_t;

    localparam payload_t c_NOP_PAYLOAD = '{
        wd:    '0,
        wreg:  c_WRITE_DISABLE,
        wdata: c_ZERO_WORD,
        hi:    c_ZERO_WORD,
        lo:    c_ZERO_WORD,
        whilo: c_WRITE_DISABLE,
        aluop: '0
    };

    typedef enum logic [2:0] {
        ACT_RESET   = 3'd0,
        ACT_FLUSH   = 3'd1,
        ACT_BUBBLE  = 3'd2,
        ACT_ADVANCE = 3'd3,
        ACT_HOLD    = 3'd4
    } stage_act_e;

    // First matching row wins; an illegal "upstream runs, downstream stalled"
    // pattern falls through to ADVANCE on purpose.
    function automatic stage_act_e decode_act(input logic in_rst,
                                              input logic in_flush,
                                              input logic up_stall,
                                              input logic dn_stall);
        if (in_rst)                    return ACT_RESET;
        if (in_flush)                  return ACT_FLUSH;
        if (up_stall && !dn_stall)     return ACT_BUBBLE;
        if (!up_stall)                 return ACT_ADVANCE;
        return ACT_HOLD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Control, payload and scratch-feedback bundle between two
//               adjacent pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if
    import pipe_stage_reg_pkg::*;
#(
    parameter int PAYLOAD_W = c_PAYLOAD_W,
    parameter int STALL_W   = 6,
    parameter int SCR_W     = 64,
    parameter int CNT_W     = 2
) ();

    logic [STALL_W-1:0]   stall;
    logic                 flush;
    logic                 in_valid;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [SCR_W-1:0]     scr_i;
    logic [CNT_W-1:0]     cnt_i;
    logic                 out_valid;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [SCR_W-1:0]     scr_o;
    logic [CNT_W-1:0]     cnt_o;

    modport master (
        output stall, flush, in_valid, in_payload, scr_i, cnt_i,
        input  out_valid, out_payload, scr_o, cnt_o
    );

    modport slave (
        input  stall, flush, in_valid, in_payload, scr_i, cnt_i,
        output out_valid, out_payload, scr_o, cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sat_cnt
// Description : Saturating up-counter with synchronous clear; clear wins over
//               a same-cycle increment.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_cnt #(
    parameter int WIDTH = 32
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              clr,
    input  wire              inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised inter-stage pipeline register with bubble
//               insertion, flush and scratch/step feedback to the upstream
//               stage. Optional perf counters under PIPE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                   PAYLOAD_W  = c_PAYLOAD_W,
    parameter int                   STALL_W    = 6,
    parameter int                   STAGE      = 3,
    parameter int                   SCR_W      = 64,
    parameter int                   CNT_W      = 2,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_VAL = {PAYLOAD_W{1'b0}}
) (
    input  wire         clk,
    input  wire         rst,
    pipe_stage_reg_if.slave bus,
    input  wire         perf_clr,
    output logic [31:0] stall_cyc,
    output logic [31:0] bubble_cyc
);

    stage_act_e           w_act;
    logic                 r_out_valid;
    logic [PAYLOAD_W-1:0] r_out_payload;
    logic [SCR_W-1:0]     r_scr;
    logic [CNT_W-1:0]     r_cnt;

    assign w_act = decode_act(rst, bus.flush, bus.stall[STAGE], bus.stall[STAGE+1]);

    always_ff @(posedge clk) begin
        case (w_act)
            ACT_RESET, ACT_FLUSH: begin
                r_out_payload <= BUBBLE_VAL;
                r_out_valid   <= 1'b0;
                r_scr         <= '0;
                r_cnt         <= '0;
            end
            ACT_BUBBLE: begin
                r_out_payload <= BUBBLE_VAL;
                r_out_valid   <= 1'b0;
                r_scr         <= bus.scr_i;
                r_cnt         <= bus.cnt_i;
            end
            ACT_ADVANCE: begin
                r_out_payload <= bus.in_payload;
                r_out_valid   <= bus.in_valid;
                r_scr         <= '0;
                r_cnt         <= '0;
            end
            default: begin
                // Downstream holds its instruction; only the feedback moves.
                r_scr <= bus.scr_i;
                r_cnt <= bus.cnt_i;
            end
        endcase
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_payload = r_out_payload;
    assign bus.scr_o       = r_scr;
    assign bus.cnt_o       = r_cnt;

    a_legal_stall: assert property (@(posedge clk) disable iff (rst || bus.flush)
        !(!bus.stall[STAGE] && bus.stall[STAGE+1]));

`ifdef PIPE_PERF_EN
    logic w_bubble;
    logic w_stalled;

    assign w_bubble  = (w_act == ACT_BUBBLE);
    assign w_stalled = (w_act == ACT_BUBBLE) || (w_act == ACT_HOLD);

    pipe_sat_cnt #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (w_stalled),
        .count (stall_cyc)
    );

    pipe_sat_cnt #(.WIDTH(32)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (w_bubble),
        .count (bubble_cyc)
    );
`else
    logic w_unused_perf_clr;

    assign w_unused_perf_clr = perf_clr;
    assign stall_cyc         = '0;
    assign bubble_cyc        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed-vector bench for pipe_stage_reg with a queued
//               scoreboard checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int PAYLOAD_W = 107;
    localparam int STALL_W   = 6;
    localparam int STAGE     = 3;
    localparam int SCR_W     = 64;
    localparam int CNT_W     = 2;

    localparam logic [PAYLOAD_W-1:0] BV     = '0;
    localparam logic [STALL_W-1:0]   S_RUN  = 6'b000000;
    localparam logic [STALL_W-1:0]   S_BUB  = 6'b001111;
    localparam logic [STALL_W-1:0]   S_HOLD = 6'b011111;
    localparam logic [PAYLOAD_W-1:0] P1 =
        {5'd7, 1'b1, 32'hDEAD_BEEF, 32'h1111_2222, 32'h3333_4444, 1'b1, 4'h5};
    localparam logic [PAYLOAD_W-1:0] P2 =
        {5'd19, 1'b1, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0, 4'hA};

    logic        clk = 1'b1;
    logic        rst;
    logic        perf_clr;
    logic [31:0] stall_cyc;
    logic [31:0] bubble_cyc;

    pipe_stage_reg_if #(.PAYLOAD_W(PAYLOAD_W), .STALL_W(STALL_W),
                        .SCR_W(SCR_W), .CNT_W(CNT_W)) bus ();

    pipe_stage_reg #(.PAYLOAD_W(PAYLOAD_W), .STALL_W(STALL_W), .STAGE(STAGE),
                     .SCR_W(SCR_W), .CNT_W(CNT_W), .BUBBLE_VAL(BV)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .perf_clr   (perf_clr),
        .stall_cyc  (stall_cyc),
        .bubble_cyc (bubble_cyc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 valid;
        logic [PAYLOAD_W-1:0] payload;
        logic [SCR_W-1:0]     scr;
        logic [CNT_W-1:0]     cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    function automatic void chk(input string nm, input string fld,
                                input logic [127:0] act, input logic [127:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s.%s: actual=%h expected=%h", nm, fld, act, want);
        end
    endfunction

    // Inputs change on the falling edge; the expectation is for the next rising edge.
    task automatic drive(input string nm, input logic r, input logic fl,
                         input logic [STALL_W-1:0] st, input logic iv,
                         input logic [PAYLOAD_W-1:0] ip, input logic [SCR_W-1:0] si,
                         input logic [CNT_W-1:0] ci, input logic ev,
                         input logic [PAYLOAD_W-1:0] ep, input logic [SCR_W-1:0] es,
                         input logic [CNT_W-1:0] ec);
        exp_t e;
        @(negedge clk);
        rst            = r;
        bus.flush      = fl;
        bus.stall      = st;
        bus.in_valid   = iv;
        bus.in_payload = ip;
        bus.scr_i      = si;
        bus.cnt_i      = ci;
        e.valid   = ev;
        e.payload = ep;
        e.scr     = es;
        e.cnt     = ec;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, "out_valid",   128'(bus.out_valid),   128'(e.valid));
                chk(nm, "out_payload", 128'(bus.out_payload), 128'(e.payload));
                chk(nm, "scr_o",       128'(bus.scr_o),       128'(e.scr));
                chk(nm, "cnt_o",       128'(bus.cnt_o),       128'(e.cnt));
`ifndef PIPE_PERF_EN
                chk(nm, "stall_cyc",   128'(stall_cyc),       128'(0));
                chk(nm, "bubble_cyc",  128'(bubble_cyc),      128'(0));
`endif
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #3;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: actual=%0d pending expected=0", exp_q.size());
        end
    endtask

    initial begin : stimulus
        logic [127:0]         rnd;
        logic [STALL_W-1:0]   rst_stall;

        rst = 1'b1; perf_clr = 1'b0;
        bus.flush = 1'b0; bus.stall = '0; bus.in_valid = 1'b0;
        bus.in_payload = '0; bus.scr_i = '0; bus.cnt_i = '0;

        rnd       = {$urandom(), $urandom(), $urandom(), $urandom()};
        rst_stall = STALL_W'($urandom());
        if (!rst_stall[STAGE]) rst_stall[STAGE+1] = 1'b0;

        drive("reset_rand", 1'b1, 1'($urandom()), rst_stall, 1'b1, rnd[PAYLOAD_W-1:0],
              rnd[SCR_W-1:0], 2'($urandom()), 1'b0, BV, 64'h0, 2'd0);
        drive("reset_run",  1'b1, 1'b0, S_RUN, 1'b1, P1, 64'hFFFF, 2'd3, 1'b0, BV, 64'h0, 2'd0);
        drive("advance_p1", 1'b0, 1'b0, S_RUN, 1'b1, P1, 64'hFFFF, 2'd3, 1'b1, P1, 64'h0, 2'd0);
        drive("bubble",     1'b0, 1'b0, S_BUB, 1'b1, P2, 64'h1234, 2'd1, 1'b0, BV, 64'h1234, 2'd1);
        drive("reload_p1",  1'b0, 1'b0, S_RUN, 1'b1, P1, 64'h0, 2'd0, 1'b1, P1, 64'h0, 2'd0);
        for (int i = 0; i < 3; i++)
            drive("hold_p1", 1'b0, 1'b0, S_HOLD, 1'b1, P2, 64'hA000 + 64'(i), 2'(i + 1),
                  1'b1, P1, 64'hA000 + 64'(i), 2'(i + 1));
        drive("flush_bub",  1'b0, 1'b1, S_BUB, 1'b1, P2, 64'h55, 2'd2, 1'b0, BV, 64'h0, 2'd0);
        drive("adv_inval",  1'b0, 1'b0, S_RUN, 1'b0, P2, 64'h9, 2'd1, 1'b0, P2, 64'h0, 2'd0);
        drive("adv_p2",     1'b0, 1'b0, S_RUN, 1'b1, P2, 64'h0, 2'd0, 1'b1, P2, 64'h0, 2'd0);
        drive("bubble2",    1'b0, 1'b0, S_BUB, 1'b1, P1, 64'hBEEF, 2'd3, 1'b0, BV, 64'hBEEF, 2'd3);
        drive("hold_bub",   1'b0, 1'b0, S_HOLD, 1'b1, P1, 64'hC0DE, 2'd2, 1'b0, BV, 64'hC0DE, 2'd2);
        drive("resume_p1",  1'b0, 1'b0, S_RUN, 1'b1, P1, 64'h3, 2'd1, 1'b1, P1, 64'h0, 2'd0);
        drive("hold_p1b",   1'b0, 1'b0, S_HOLD, 1'b1, P2, 64'h77, 2'd1, 1'b1, P1, 64'h77, 2'd1);
        drive("flush_hold", 1'b0, 1'b1, S_HOLD, 1'b1, P2, 64'h88, 2'd3, 1'b0, BV, 64'h0, 2'd0);
        drive("reload_p2",  1'b0, 1'b0, S_RUN, 1'b1, P2, 64'h0, 2'd0, 1'b1, P2, 64'h0, 2'd0);
        drive("hold_p2",    1'b0, 1'b0, S_HOLD, 1'b1, P1, 64'h99, 2'd2, 1'b1, P2, 64'h99, 2'd2);
        drive("rst_mid",    1'b1, 1'b0, S_HOLD, 1'b1, P1, 64'hAA, 2'd3, 1'b0, BV, 64'h0, 2'd0);
        drive("restart",    1'b0, 1'b0, S_BUB, 1'b1, P1, 64'h1, 2'd0, 1'b0, BV, 64'h1, 2'd0);
        drain();

`ifdef PIPE_PERF_EN
        drive("perf_rst", 1'b1, 1'b0, S_RUN, 1'b0, P1, 64'h0, 2'd0, 1'b0, BV, 64'h0, 2'd0);
        for (int i = 0; i < 4; i++)
            drive("perf_hold", 1'b0, 1'b0, S_HOLD, 1'b1, P1, 64'(i), 2'(i),
                  1'b0, BV, 64'(i), 2'(i));
        for (int i = 0; i < 2; i++)
            drive("perf_bub", 1'b0, 1'b0, S_BUB, 1'b1, P1, 64'h10 + 64'(i), 2'd1,
                  1'b0, BV, 64'h10 + 64'(i), 2'd1);
        drain();
        chk("perf_count", "stall_cyc",  128'(stall_cyc),  128'(6));
        chk("perf_count", "bubble_cyc", 128'(bubble_cyc), 128'(2));

        @(negedge clk);
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("perf_clr", "stall_cyc",  128'(stall_cyc),  128'(0));
        chk("perf_clr", "bubble_cyc", 128'(bubble_cyc), 128'(0));
        @(negedge clk);
        perf_clr = 1'b0;
        force dut.u_stall_cnt.r_count  = 32'hFFFF_FFFF;
        force dut.u_bubble_cnt.r_count = 32'hFFFF_FFFF;
        #1;
        release dut.u_stall_cnt.r_count;
        release dut.u_bubble_cnt.r_count;
        @(posedge clk);
        #1;
        chk("perf_sat", "stall_cyc",  128'(stall_cyc),  128'(32'hFFFF_FFFF));
        chk("perf_sat", "bubble_cyc", 128'(bubble_cyc), 128'(32'hFFFF_FFFF));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
